// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand modular adder: operands fold into a carry-save pair, one CPA resolves.
// Optional macro CSA_OVERFLOW_EN adds the sticky out_overflow port.
module csa_stream_accumulator #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned MAX_OPERANDS = 8,
  localparam int unsigned CNT_W       = $clog2(MAX_OPERANDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_forced
`ifdef CSA_OVERFLOW_EN
  ,
  output logic             out_overflow
`endif
);

  typedef enum logic [1:0] {StAccum, StResolve, StOutput} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sum_q;
  // carry[WIDTH-1] is never kept: it is shifted out (discarded) by the next accept or the CPA.
  logic [WIDTH-2:0] carry_q;
  logic [CNT_W-1:0] count_q;

  logic [WIDTH-1:0] c2;
  logic [WIDTH-1:0] sum_nx;
  logic [WIDTH-2:0] carry_nx;
  logic [CNT_W-1:0] count_nx;
  logic             accept;
  logic             at_max;

  always_comb begin
    c2       = {carry_q, 1'b0};
    sum_nx   = sum_q ^ c2 ^ in_data;
    carry_nx = (sum_q[WIDTH-2:0] & c2[WIDTH-2:0]) | (sum_q[WIDTH-2:0] & in_data[WIDTH-2:0]) |
               (c2[WIDTH-2:0] & in_data[WIDTH-2:0]);
    count_nx = count_q + 1'b1;
    at_max   = (count_nx == CNT_W'(MAX_OPERANDS));
    accept   = in_valid && (state_q == StAccum);
  end

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StOutput);

`ifdef CSA_OVERFLOW_EN
  logic             ovf_q;
  logic             carry_top;
  logic [WIDTH:0]   resolve_full;

  // Weight-2^WIDTH carry produced by this accept; it is dropped later, so fold it into ovf now.
  assign carry_top    = (sum_q[WIDTH-1] & c2[WIDTH-1]) | (sum_q[WIDTH-1] & in_data[WIDTH-1]) |
                        (c2[WIDTH-1] & in_data[WIDTH-1]);
  assign resolve_full = {1'b0, sum_q} + {1'b0, c2};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StAccum;
      sum_q      <= '0;
      carry_q    <= '0;
      count_q    <= '0;
      out_data   <= '0;
      out_count  <= '0;
      out_forced <= 1'b0;
`ifdef CSA_OVERFLOW_EN
      ovf_q        <= 1'b0;
      out_overflow <= 1'b0;
`endif
    end else begin
      case (state_q)
        StAccum: begin
          if (accept) begin
            sum_q   <= sum_nx;
            carry_q <= carry_nx;
            count_q <= count_nx;
`ifdef CSA_OVERFLOW_EN
            ovf_q   <= ovf_q | carry_top;
`endif
            if (in_last || at_max) begin
              state_q    <= StResolve;
              out_forced <= !in_last && at_max;
            end
          end
        end
        StResolve: begin
`ifdef CSA_OVERFLOW_EN
          out_data     <= resolve_full[WIDTH-1:0];
          out_overflow <= ovf_q | resolve_full[WIDTH];
`else
          out_data     <= sum_q + c2;
`endif
          out_count <= count_q;
          state_q   <= StOutput;
        end
        StOutput: begin
          if (out_ready) begin
            sum_q   <= '0;
            carry_q <= '0;
            count_q <= '0;
`ifdef CSA_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
            state_q <= StAccum;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed self-checking bench for csa_stream_accumulator (WIDTH=32, MAX_OPERANDS=8).
module tb_csa_stream_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_count;
  logic        out_forced;
`ifdef CSA_OVERFLOW_EN
  logic        out_overflow;
`endif

  int vectors = 0;
  int errors  = 0;

  csa_stream_accumulator #(
    .WIDTH(32),
    .MAX_OPERANDS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_count(out_count),
    .out_forced(out_forced)
`ifdef CSA_OVERFLOW_EN
    , .out_overflow(out_overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++;
    if (out_data !== 32'h0 || out_count !== 4'd0 || out_forced !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got %h/%0d/%b want 0/0/0", out_data, out_count, out_forced);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_sum();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      vectors++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL t1_ready_%0d got %b want 1", i, in_ready); end
      send(32'(i), i == 5);
    end
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL t1_resolve got v=%b r=%b want v=0 r=0", out_valid, in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL t1_latency got %b want 1", out_valid); end
    vectors++;
    if (out_data !== 32'h0000000F || out_count !== 4'd5 || out_forced !== 1'b0) begin
      errors++;
      $display("FAIL t1_result got %h/%0d/%b want 0000000f/5/0", out_data, out_count, out_forced);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL t1_handoff got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_single_operand();
    send(32'hDEADBEEF, 1'b1);
    vectors++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL t2_resolve_ready got %b want 0", in_ready); end
    tick();
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL t2_output got r=%b v=%b want r=0 v=1", in_ready, out_valid);
    end
    vectors++;
    if (out_data !== 32'hDEADBEEF || out_count !== 4'd1) begin
      errors++; $display("FAIL t2_result got %h/%0d want deadbeef/1", out_data, out_count);
    end
    tick();
  endtask

  task automatic test_wrap();
    send(32'hFFFFFFFF, 1'b0);
    send(32'h00000001, 1'b0);
    send(32'h00000002, 1'b1);
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h00000002 || out_count !== 4'd3) begin
      errors++; $display("FAIL t3_wrap got v=%b %h/%0d want 1 00000002/3", out_valid, out_data, out_count);
    end
`ifdef CSA_OVERFLOW_EN
    vectors++;
    if (out_overflow !== 1'b1) begin errors++; $display("FAIL t3_ovf_set got %b want 1", out_overflow); end
`endif
    tick();
    send(32'h6a09e667, 1'b0);
    send(32'h0000000a, 1'b1);
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h6a09e671 || out_count !== 4'd2) begin
      errors++; $display("FAIL t3_sha got v=%b %h/%0d want 1 6a09e671/2", out_valid, out_data, out_count);
    end
`ifdef CSA_OVERFLOW_EN
    vectors++;
    if (out_overflow !== 1'b0) begin errors++; $display("FAIL t3_ovf_clear got %b want 0", out_overflow); end
`endif
    tick();
  endtask

  task automatic test_forced();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1; in_last = 1'b0;
    repeat (8) tick();
    in_data = 32'h9; in_last = 1'b1;
    vectors++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL t4_ninth_held got %b want 0", in_ready); end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h8 || out_count !== 4'd8 || out_forced !== 1'b1) begin
      errors++;
      $display("FAIL t4_forced got v=%b %h/%0d/%b want 1 00000008/8/1", out_valid, out_data,
               out_count, out_forced);
    end
    vectors++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL t4_output_ready got %b want 0", in_ready); end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL t4_handoff got r=%b v=%b want r=1 v=0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h9 || out_count !== 4'd1 || out_forced !== 1'b0) begin
      errors++;
      $display("FAIL t4_ninth got v=%b %h/%0d/%b want 1 00000009/1/0", out_valid, out_data,
               out_count, out_forced);
    end
    tick();
  endtask

  task automatic test_back_to_back_stall();
    out_ready = 1'b0;
    send(32'h5, 1'b1);
    tick();
    in_valid = 1'b1; in_data = 32'h7; in_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'h5 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL t5_stall_%0d got v=%b d=%h r=%b want v=1 d=00000005 r=0", k, out_valid,
                 out_data, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h5) begin
      errors++;
      $display("FAIL t5_release got r=%b v=%b d=%h want r=1 v=0 d=00000005", in_ready, out_valid,
               out_data);
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h7 || out_count !== 4'd1) begin
      errors++; $display("FAIL t5_next got v=%b %h/%0d want 1 00000007/1", out_valid, out_data, out_count);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    send(32'h1, 1'b0);
    send(32'h2, 1'b0);
    send(32'h3, 1'b0);
    rst = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 4'd0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL t6_reset got r=%b v=%b c=%0d d=%h want r=1 v=0 c=0 d=0", in_ready, out_valid,
               out_count, out_data);
    end
    tick();
    rst = 1'b0;
    tick();
    send(32'd10, 1'b0);
    send(32'd20, 1'b1);
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'd30 || out_count !== 4'd2) begin
      errors++; $display("FAIL t6_after got v=%b %0d/%0d want 1 30/2", out_valid, out_data, out_count);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_single_operand();
    test_wrap();
    test_forced();
    test_back_to_back_stall();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/csa_stream_accumulator.md
Name: csa_stream_accumulator

Overview:
Multi-operand modular adder for the SHA-256 round datapath, e.g. T1 = h + Σ1 + Ch + K + W.
- Operands stream in one per cycle over a valid/ready handshake.
- Operands accumulate in redundant carry-save form (sum/carry pair), so there is no carry propagation per operand.
- One final carry-propagate stage resolves the pair into a WIDTH-bit result modulo 2^WIDTH.
- Parametrised successor of the single-shot 3:2 carry-save adder: adds width/depth generality, a sequencing FSM and handshaking.

Parameters:
WIDTH, 32, operand/result width in bits (>=2).
MAX_OPERANDS, 8, operands per transaction before a forced termination (>=2).
CNT_W, $clog2(MAX_OPERANDS+1), operand counter width (derived, do not override).

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operand valid
in_ready  output  1  block can accept operand
in_data  input  WIDTH  operand
in_last  input  1  final operand of transaction
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  WIDTH  (sum of operands) mod 2^WIDTH
out_count  output  CNT_W  number of operands summed
out_forced  output  1  transaction ended by MAX_OPERANDS, not in_last
out_overflow  output  1  only with CSA_OVERFLOW_EN (see below)

Behaviour:
- Reset (async assert, sync release): state ACCUM; sum, carry and count cleared; in_ready=1, out_valid=0, out_data=0, out_count=0, out_forced=0, out_overflow=0.
- State ACCUM:
  - in_ready=1. An operand is accepted when in_valid && in_ready on a rising edge.
  - On accept: sum' = sum ^ c2 ^ in_data and carry' = maj(sum, c2, in_data), where c2 = {carry[WIDTH-2:0],1'b0}.
  - carry[WIDTH-1] shifted out is discarded (modular).
  - count increments on every accept.
- ACCUM exit: if the accepted operand has in_last=1, or count reaches MAX_OPERANDS on this accept, go to RESOLVE.
  - out_forced = (!in_last && count == MAX_OPERANDS) latched at this point.
- State RESOLVE, exactly one cycle:
  - in_ready=0.
  - out_data <= sum + {carry[WIDTH-2:0],1'b0} mod 2^WIDTH; out_count <= count.
  - go to OUTPUT.
- State OUTPUT:
  - in_ready=0; out_valid=1.
  - out_data, out_count, out_forced and out_overflow held stable while out_ready=0.
  - On out_valid && out_ready: sum, carry and count cleared; go to ACCUM; out_valid drops next cycle.
  - out_data and out_count keep their last value after handoff.
- Latency: out_valid high 2 rising edges after the edge that accepts the last operand.
- Throughput: N operands need N+2 cycles plus output stall cycles.
- A single-operand transaction (in_last on the first operand) returns that operand unchanged, out_count=1.
- in_valid while in_ready=0 is ignored. No operand is lost, because upstream holds it.
- in_last with in_valid=0 has no effect.
- Reset asserted mid-transaction or mid-OUTPUT: partial state discarded immediately, outputs return to reset values. No result is emitted for the aborted transaction.
- All arithmetic is unsigned modulo 2^WIDTH. The final adder is a plain behavioural + (no operator-level carry-out used except under the macro).

Optional Feature:
CSA_OVERFLOW_EN:
- Defined:
  - A sticky flag sets whenever a shifted-out carry[WIDTH-1] is 1 during an ACCUM accept, or when the RESOLVE add produces carry-out.
  - out_overflow = that flag, updated at RESOLVE. It is 1 exactly when the true integer sum >= 2^WIDTH.
  - The flag clears with the transaction, and on reset.
- Undefined: port out_overflow is absent and no overflow logic is synthesised.

Test Plan:
1. WIDTH=32: stream 1,2,3,4,5 (in_last on 5), out_ready=1 -> out_data=0x0000000F, out_count=5, out_forced=0, out_valid exactly 2 edges after accepting 5, high for 1 cycle.
2. Single operand 0xDEADBEEF with in_last -> out_data=0xDEADBEEF, out_count=1; in_ready=0 for RESOLVE and OUTPUT cycles.
3. Stream 0xFFFFFFFF, 0x00000001, 0x00000002 (last) -> out_data=0x00000002; with CSA_OVERFLOW_EN out_overflow=1. Then stream 0x6a09e667, 0x0000000a (last) -> 0x6a09e671, out_overflow=0.
4. MAX_OPERANDS=8: stream eight 0x00000001 with in_last=0 -> out_data=8, out_count=8, out_forced=1; the ninth operand is held (in_ready=0) until after handoff and then starts a new transaction.
5. Hold out_ready=0 for 3 cycles after out_valid -> out_valid and out_data stable all 3 cycles; in_valid=1 with in_data=7 held throughout is not accepted until the cycle after out_ready=1.
6. Assert rst for 1 cycle after 3 of 5 operands are accepted -> in_ready=1, out_valid=0, counters 0; a following transaction of 10,20 (last) yields exactly 30.
